// File: rtl/prio_encoder_rr_pkg.sv
// prio_enc_pkg: shared constants and helpers for the round-robin priority encoder.
// Mode encodings for mode_rr, and ch_val() to slice one channel out of a packed
// channel vector. Imported by prio_pick and prio_encoder_rr.
package prio_enc_pkg;

  localparam logic PRIO_FIXED = 1'b0;
  localparam logic PRIO_RR    = 1'b1;

  // Upper bounds for the generic slicing helper; callers zero-extend into these
  // and truncate the result back to their own VAL_W.
  localparam int MAX_VEC_W = 1024;
  localparam int MAX_VAL_W = 32;

  // Returns channel i (val_w bits, LSB-aligned) from a packed vector where
  // channel i occupies bits [i*val_w +: val_w].
  function automatic logic [MAX_VAL_W-1:0] ch_val(input logic [MAX_VEC_W-1:0] vec,
                                                  input int i,
                                                  input int val_w = 2);
    logic [MAX_VEC_W-1:0] sh;
    sh = vec >> (i * val_w);
    return sh[MAX_VAL_W-1:0] & ({MAX_VAL_W{1'b1}} >> (MAX_VAL_W - val_w));
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// prio_encoder_rr_if: put/get handshake bundle for prio_encoder_rr.
// Put side: put_vec, mode_rr, EN_put / RDY_put. Get side: EN_get / RDY_get with
// get_idx, get_val, get_any, mv_busy (plus get_multi/get_cnt when PRIO_ENC_MULTI_EN).
interface prio_encoder_rr_if #(
  parameter int NUM_CH = 8,
  parameter int VAL_W  = 2
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(NUM_CH + 1);

  logic [NUM_CH*VAL_W-1:0] put_vec;
  logic                    mode_rr;
  logic                    EN_put;
  logic                    RDY_put;
  logic                    EN_get;
  logic                    RDY_get;
  logic [IDX_W-1:0]        get_idx;
  logic [VAL_W-1:0]        get_val;
  logic                    get_any;
  logic                    mv_busy;
`ifdef PRIO_ENC_MULTI_EN
  logic                    get_multi;
  logic [CNT_W-1:0]        get_cnt;
`endif

  // slave: the encoder itself
  modport slave (
    input  put_vec, mode_rr, EN_put, EN_get,
    output RDY_put, RDY_get, get_idx, get_val, get_any, mv_busy
`ifdef PRIO_ENC_MULTI_EN
    , output get_multi, get_cnt
`endif
  );

  // master: whoever drives requests and drains results
  modport master (
    output put_vec, mode_rr, EN_put, EN_get,
    input  RDY_put, RDY_get, get_idx, get_val, get_any, mv_busy
`ifdef PRIO_ENC_MULTI_EN
    , input get_multi, get_cnt
`endif
  );

endinterface

// File: rtl/prio_encoder_rr_pick.sv
// prio_pick: combinational winner search over an active mask.
// Ports: mask (active channels), ptr (round-robin pointer), mode (fixed/RR) in;
// win (winning index, 0 when none) and found out. Zero latency, no backpressure.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [IDX_W-1:0]  win,
  output logic              found
);

  // Fixed priority is the RR search with the pointer forced to 0, so one
  // search path serves both modes.
  int                start;
  int                j;
  int                pos;
  logic [NUM_CH-1:0] rot;

  always_comb begin
    start = (mode == PRIO_RR) ? int'(ptr) : 0;
    rot   = '0;
    j     = 0;
    pos   = 0;
    found = 1'b0;
    win   = '0;

    // rot[k] holds channel (start-1-k) mod NUM_CH, so rot[0] is top priority.
    for (int k = 0; k < NUM_CH; k++) begin
      j = start - 1 - k;
      if (j < 0) j = j + NUM_CH;
      rot[k] = mask[IDX_W'(j)];
    end

    // Find-first from rot[0]; scanning downward lets the lowest k win.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos   = k;
        found = 1'b1;
      end
    end

    // Un-rotate back to a channel number; a single wrap is enough since
    // start-1-pos >= -NUM_CH.
    j = start - 1 - pos;
    if (j < 0) j = j + NUM_CH;
    if (found) win = IDX_W'(j);
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder, fixed or round-robin per put.
// Latency 1 cycle put->get; one-entry output register. RDY_put = !full || EN_get
// (same-cycle pass-through while draining). Optional PRIO_ENC_MULTI_EN adds get_multi/get_cnt.
// Ports: CLK, RST_N (sync, active-low), bus (prio_encoder_rr_if.slave).
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int VAL_W  = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  prio_encoder_rr_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(NUM_CH + 1);

  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("prio_encoder_rr: NUM_CH must be >= 2");
  end

  logic [VAL_W-1:0]  vals [NUM_CH];
  logic [NUM_CH-1:0] mask;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win;
  logic              found;
  logic              full;
  logic              put_fire;
  logic              get_fire;
  logic [IDX_W-1:0]  idx_q;
  logic [VAL_W-1:0]  val_q;
  logic              any_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      vals[i] = VAL_W'(ch_val(MAX_VEC_W'(bus.put_vec), i, VAL_W));
      mask[i] = |vals[i];
    end
  end

  prio_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .mask  (mask),
    .ptr   (ptr),
    .mode  (bus.mode_rr),
    .win   (win),
    .found (found)
  );

  assign bus.RDY_put = !full || bus.EN_get;
  assign put_fire    = bus.EN_put && bus.RDY_put;
  assign get_fire    = bus.EN_get && full;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      full  <= 1'b0;
      ptr   <= '0;
      idx_q <= '0;
      val_q <= '0;
      any_q <= 1'b0;
    end else if (put_fire) begin
      // A put wins over a concurrent get: the slot is refilled and stays full.
      full  <= 1'b1;
      idx_q <= win;
      val_q <= found ? vals[win] : '0;
      any_q <= found;
      if (bus.mode_rr == PRIO_RR && found) ptr <= win;
    end else if (get_fire) begin
      full <= 1'b0;
    end
  end

  assign bus.RDY_get = full;
  assign bus.mv_busy = full;
  assign bus.get_idx = idx_q;
  assign bus.get_val = val_q;
  assign bus.get_any = any_q;

`ifdef PRIO_ENC_MULTI_EN
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             multi_q;

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) cnt_nxt = cnt_nxt + CNT_W'(mask[i]);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      multi_q <= 1'b0;
    end else if (put_fire) begin
      cnt_q   <= cnt_nxt;
      multi_q <= (cnt_nxt > CNT_W'(1));
    end
  end

  assign bus.get_cnt   = cnt_q;
  assign bus.get_multi = multi_q;
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr (NUM_CH=8, VAL_W=2): directed cases
// followed by constrained-random traffic checked against a behavioural model.
module tb_prio_encoder_rr;

  localparam int N = 8;
  localparam int W = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  prio_encoder_rr_if #(.NUM_CH(N), .VAL_W(W)) bus ();

  prio_encoder_rr #(.NUM_CH(N), .VAL_W(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference state
  bit m_full;
  int m_idx, m_val, m_ptr, m_cnt;
  bit m_any;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int chan(input logic [15:0] v, input int c);
    return int'(v[c*W +: W]);
  endfunction

  // Winner by the stated rules: fixed = highest active channel; RR = first
  // active among ptr-1, ptr-2, ... ptr (mod N). -1 when nothing is active.
  function automatic int ref_pick(input logic [15:0] v, input bit rr, input int p);
    if (!rr) begin
      for (int c = N - 1; c >= 0; c--) if (chan(v, c) != 0) return c;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (p - k + N) % N;
        if (chan(v, c) != 0) return c;
      end
    end
    return -1;
  endfunction

  function automatic int ref_cnt(input logic [15:0] v);
    int n = 0;
    for (int c = 0; c < N; c++) if (chan(v, c) != 0) n++;
    return n;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_rdy_get"}, bus.RDY_get, m_full);
    chk({tag, "_busy"}, bus.mv_busy, m_full);
    if (m_full) begin
      chk({tag, "_idx"}, bus.get_idx, m_idx);
      chk({tag, "_val"}, bus.get_val, m_val);
      chk({tag, "_any"}, bus.get_any, m_any);
`ifdef PRIO_ENC_MULTI_EN
      chk({tag, "_cnt"}, bus.get_cnt, m_cnt);
      chk({tag, "_multi"}, bus.get_multi, m_cnt > 1);
`endif
    end
  endtask

  // One clock cycle with the given inputs; model tracks what should happen.
  task automatic cyc(input logic [15:0] v, input bit rr, input bit ep, input bit eg,
                     input string tag);
    bit pf, gf;
    int w;
    bus.put_vec = v;
    bus.mode_rr = rr;
    bus.EN_put  = ep;
    bus.EN_get  = eg;
    #1;
    chk({tag, "_rdy_put"}, bus.RDY_put, (!m_full || eg));
    pf = ep && (!m_full || eg);
    gf = eg && m_full;
    @(posedge CLK);
    #1;
    if (pf) begin
      w      = ref_pick(v, rr, m_ptr);
      m_full = 1;
      m_any  = (w >= 0);
      m_idx  = 0;
      m_val  = 0;
      if (w >= 0) begin
        m_idx = w;
        m_val = chan(v, w);
        if (rr) m_ptr = w;
      end
      m_cnt = ref_cnt(v);
    end else if (gf) begin
      m_full = 0;
    end
    bus.EN_put = 1'b0;
    bus.EN_get = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    bus.EN_put = 1'b0;
    bus.EN_get = 1'b0;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    m_full = 0; m_idx = 0; m_val = 0; m_any = 0; m_ptr = 0; m_cnt = 0;
    chk({tag, "_rdy_get"}, bus.RDY_get, 0);
    chk({tag, "_busy"}, bus.mv_busy, 0);
    chk({tag, "_idx"}, bus.get_idx, 0);
    chk({tag, "_val"}, bus.get_val, 0);
    chk({tag, "_any"}, bus.get_any, 0);
    chk({tag, "_rdy_put"}, bus.RDY_put, 1);
`ifdef PRIO_ENC_MULTI_EN
    chk({tag, "_cnt"}, bus.get_cnt, 0);
    chk({tag, "_multi"}, bus.get_multi, 0);
`endif
  endtask

  initial begin
    int exp_rr [4] = '{5, 2, 5, 2};
    logic [15:0] rot_vec;
    logic [15:0] rv;
    bit rr, ep, eg;

    bus.put_vec = '0;
    bus.mode_rr = 1'b0;
    bus.EN_put  = 1'b0;
    bus.EN_get  = 1'b0;
    m_full = 0; m_idx = 0; m_val = 0; m_any = 0; m_ptr = 0; m_cnt = 0;

    // Reset state
    @(posedge CLK);
    do_reset("reset");

    // Fixed priority: ch7=01, ch3=11 -> idx 7, val 01
    cyc(16'h4000 | 16'h00C0, 1'b0, 1'b1, 1'b0, "fixed");
    chk("fixed_idx_const", bus.get_idx, 7);
    chk("fixed_val_const", bus.get_val, 1);
    chk("fixed_any_const", bus.get_any, 1);

    // No active channel (drain + put same cycle)
    cyc(16'h0000, 1'b0, 1'b1, 1'b1, "none");
    chk("none_any_const", bus.get_any, 0);
    chk("none_idx_const", bus.get_idx, 0);
    chk("none_val_const", bus.get_val, 0);
    chk("none_rdy_const", bus.RDY_get, 1);

    // RR grant after the empty put: ptr still 0, ch1 only -> 1
    cyc(16'h0004, 1'b1, 1'b1, 1'b1, "rr_after_none");
    chk("rr_after_none_idx_const", bus.get_idx, 1);

    // Round-robin rotation: ch5=10, ch2=01 held, put+get every cycle
    rot_vec = 16'h0800 | 16'h0010;
    for (int i = 0; i < 4; i++) begin
      cyc(rot_vec, 1'b1, 1'b1, 1'b1, "rr_rot");
      chk("rr_rot_grant", bus.get_idx, exp_rr[i]);
    end

    // Backpressure and pass-through
    cyc(16'h0000, 1'b0, 1'b0, 1'b1, "drain");
    cyc(16'h0300, 1'b0, 1'b1, 1'b0, "bp_load");
    chk("bp_rdy_put_low", bus.RDY_put, 0);
    cyc(16'h1000, 1'b0, 1'b1, 1'b0, "bp_ignored");
    chk("bp_ignored_idx", bus.get_idx, 4);
    chk("bp_ignored_val", bus.get_val, 3);
    cyc(16'h0008, 1'b0, 1'b1, 1'b1, "pass");
    chk("pass_idx", bus.get_idx, 1);
    chk("pass_val", bus.get_val, 2);
    chk("pass_rdy_get", bus.RDY_get, 1);

    // Reset mid-operation (result held), then RR with ch0 and ch7
    do_reset("mid_reset");
    cyc(16'h4001, 1'b1, 1'b1, 1'b0, "post_reset_rr");
    chk("post_reset_rr_idx", bus.get_idx, 7);

`ifdef PRIO_ENC_MULTI_EN
    cyc(16'h1005, 1'b0, 1'b1, 1'b1, "multi3");
    chk("multi3_multi", bus.get_multi, 1);
    chk("multi3_cnt", bus.get_cnt, 3);
    chk("multi3_idx", bus.get_idx, 6);
    cyc(16'h0040, 1'b0, 1'b1, 1'b1, "multi1");
    chk("multi1_multi", bus.get_multi, 0);
    chk("multi1_cnt", bus.get_cnt, 1);
`endif

    // Random traffic with legal handshakes
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rv = 16'h0000;
      else if ($urandom_range(0, 5) == 0) rv = rv & 16'h0303;
      rr = 1'($urandom_range(0, 1));
      eg = m_full && ($urandom_range(0, 3) != 0);
      ep = (!m_full || eg) && ($urandom_range(0, 3) != 0);
      cyc(rv, rr, ep, eg, "rand");
      if (i == 200) do_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered priority encoder. Successor to the fixed 8x2-bit channel encoder.
- Compresses NUM_CH channels of VAL_W bits each into a winning channel index, that channel's value, and an any-active flag.
- Two arbitration modes, selected per request: fixed priority or round-robin.
- Sits between the channel sources and the narrow transmit link. Uses an EN/RDY put/get handshake with a one-entry output register.

Parameters:
- NUM_CH, 8: number of input channels; must be >= 2 (elaboration error otherwise).
- VAL_W, 2: width of each channel value.
- IDX_W, $clog2(NUM_CH): localparam; width of the winning index.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- put_vec  in  NUM_CH*VAL_W  channel i occupies bits [i*VAL_W +: VAL_W].
- mode_rr  in  1  0 = fixed priority; 1 = round-robin. Sampled when put fires.
- EN_put  in  1  put request.
- RDY_put  out  1  block can accept a put this cycle.
- EN_get  in  1  consumer takes the held result.
- RDY_get  out  1  a result is held.
- get_idx  out  IDX_W  winning channel index.
- get_val  out  VAL_W  value of the winning channel.
- get_any  out  1  at least one channel was active.
- mv_busy  out  1  equals RDY_get; an undrained result is held.

Behaviour:
- Channel i is active when its value != 0.
- put fires on EN_put && RDY_put. get fires on EN_get && RDY_get. EN_put while !RDY_put, or EN_get while !RDY_get, is ignored; the bench asserts this never happens.
- Fixed mode: the highest active index wins.
- Round-robin mode: search order is ptr-1, ptr-2, ... with wrap from 0 to NUM_CH-1, ending at ptr (lowest priority).
  - On a put fire in RR mode with any channel active, ptr <= the winning index.
  - Otherwise ptr is unchanged. Fixed-mode puts never modify ptr.
- No channel active: get_any=0, get_idx=0, get_val=0; ptr unchanged.
- Latency: the result is visible on get_* and RDY_get=1 the cycle after the put fires.
- Outputs come directly from registers. get_* hold stable while full=1 and no put fires.
- RDY_put = !full || EN_get, giving same-cycle pass-through when draining.
- Put and get fire in the same cycle while full: the new result is loaded and full stays 1.
- Get fires without a put: full <= 0. get_* keep their last values but are meaningless.
- Reset (RST_N=0 at an edge, including mid-operation): full=0, get_idx=0, get_val=0, get_any=0, ptr=0. Any held result is discarded.
- With ptr=0 the first RR search order is NUM_CH-1 down to 0, identical to fixed priority.
- Index arithmetic is modulo NUM_CH; this holds for non-power-of-2 NUM_CH as well (e.g. 5 wraps 0 to 4).

Optional Feature:
- Macro: PRIO_ENC_MULTI_EN.
- Defined:
  - Adds output get_multi (1 bit): more than one channel was active in the captured vector.
  - Adds output get_cnt ($clog2(NUM_CH+1) bits): number of active channels.
  - Both are registered alongside get_*; reset value 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package prio_enc_pkg holds:
  - mode constants PRIO_FIXED=1'b0 and PRIO_RR=1'b1;
  - a channel-slice function ch_val(vec, i).
- One combinational sub-module, prio_pick: inputs are the active mask, start pointer and mode; outputs are the winner index and a found flag. It performs rotate, find-first and un-rotate.
- The top level holds ptr, the output register, full, and the handshake.

Test Plan (NUM_CH=8, VAL_W=2):
- Fixed-mode priority: after reset, put ch7=01 and ch3=11 in fixed mode -> next cycle RDY_get=1, get_idx=7, get_val=01, get_any=1.
- No active channel: put all-zero vector -> get_any=0, get_idx=0, get_val=0, RDY_get=1; a subsequent RR grant is unaffected.
- Round-robin rotation: RR mode, ch5=10 and ch2=01 held, put+get every cycle -> grants 5, 2, 5, 2.
- Backpressure and pass-through:
  - put with EN_get=0 -> next cycle RDY_put=0, and an EN_put asserted then is ignored;
  - then EN_get=1 with EN_put=1 in the same cycle -> new result loaded, RDY_get stays 1.
- Reset mid-operation: result held, RST_N=0 for one cycle -> RDY_get=0, mv_busy=0, outputs 0; next RR put with ch0 and ch7 active -> idx=7.
- PRIO_ENC_MULTI_EN defined: ch0, ch1, ch6 active -> get_multi=1, get_cnt=3, get_idx=6; a single active channel -> get_multi=0, get_cnt=1.
